// File: rtl/cpu_sequencer.sv
// Control sequencer for the 512-bit vector cpu: accepts one 16-bit instruction at a time and
// drives the cpu control pins for the exact cycles the register file and memory need.
module cpu_sequencer #(
    parameter logic [8:0]  ADDR_MAX = 9'd496,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [2:0]       regnum,
    output logic             loadreg,
    output logic             initialize,
    output logic             load,
    output logic             store,
    output logic             add,
    output logic             mul,
    output logic [8:0]       address,
    input  logic             invalidmemaddress,
    output logic             done,
    output logic             addr_err,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {StIdle, StExec, StWb, StReject, StDone, StHalt} state_e;

    localparam logic [2:0] OpInit  = 3'd1;
    localparam logic [2:0] OpLoad  = 3'd2;
    localparam logic [2:0] OpStore = 3'd3;
    localparam logic [2:0] OpAdd   = 3'd4;
    localparam logic [2:0] OpMul   = 3'd5;
    localparam logic [2:0] OpHalt  = 3'd6;

    state_e           state_q, state_d;
    logic [15:0]      instr_q, cur;
    logic             rejected_q;
    logic             accept, is_mem;
    logic [2:0]       op;
    logic [1:0]       rg;
    logic [8:0]       ad;

    logic [2:0]       regnum_d;
    logic [8:0]       address_d;
    logic             loadreg_d, initialize_d, load_d, store_d, add_d, mul_d;
    logic             done_d, ready_d, halted_d, err_d;
    logic [CNT_W-1:0] cnt_d;

    assign accept = instr_valid & instr_ready;
    // The accept edge already has to drive EXEC outputs, so decode the incoming word directly.
    assign cur    = accept ? instr : instr_q;
    assign op     = cur[15:13];
    assign rg     = cur[12:11];
    assign ad     = cur[8:0];
    assign is_mem = (op == OpLoad) || (op == OpStore);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = (is_mem && (ad > ADDR_MAX)) ? StReject : StExec;
            StExec:   state_d = (op == OpLoad) ? StWb : StDone;
            StWb:     state_d = StDone;
            StReject: state_d = StDone;
            StDone:   state_d = (op == OpHalt) ? StHalt : StIdle;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        regnum_d     = 3'b000;
        address_d    = 9'd0;
        loadreg_d    = 1'b0;
        initialize_d = 1'b0;
        load_d       = 1'b0;
        store_d      = 1'b0;
        add_d        = 1'b0;
        mul_d        = 1'b0;
        done_d       = 1'b0;
        if (state_d == StExec) begin
            case (op)
                OpInit: begin
                    if (!rg[1]) begin
                        initialize_d = 1'b1;
                        loadreg_d    = 1'b1;
                        regnum_d     = {1'b0, rg};
                    end
                end
                OpLoad: begin
                    load_d    = 1'b1;
                    regnum_d  = {1'b0, rg};
                    address_d = ad;
                end
                OpStore: begin
                    store_d   = 1'b1;
                    regnum_d  = {1'b0, rg};
                    address_d = ad;
                end
                OpAdd: begin
                    add_d     = 1'b1;
                    loadreg_d = 1'b1;
                    regnum_d  = 3'b100;
                end
                OpMul: begin
                    mul_d     = 1'b1;
                    loadreg_d = 1'b1;
                    regnum_d  = 3'b100;
                end
                default: ;
            endcase
        end else if (state_d == StWb) begin
            loadreg_d = 1'b1;
            regnum_d  = {1'b0, rg};
            address_d = ad;
        end else if (state_d == StDone) begin
            done_d = 1'b1;
        end
        ready_d  = (state_d == StIdle);
        halted_d = (state_d == StHalt);
        err_d    = addr_err | (state_q == StReject) |
                   ((state_q == StExec) & is_mem & invalidmemaddress);
        cnt_d    = retired_cnt + CNT_W'((state_q == StDone) && !rejected_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            instr_q     <= 16'd0;
            rejected_q  <= 1'b0;
            regnum      <= 3'b000;
            address     <= 9'd0;
            loadreg     <= 1'b0;
            initialize  <= 1'b0;
            load        <= 1'b0;
            store       <= 1'b0;
            add         <= 1'b0;
            mul         <= 1'b0;
            done        <= 1'b0;
            instr_ready <= 1'b1;
            halted      <= 1'b0;
            addr_err    <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= cur;
            if (accept) rejected_q <= (state_d == StReject);
            regnum      <= regnum_d;
            address     <= address_d;
            loadreg     <= loadreg_d;
            initialize  <= initialize_d;
            load        <= load_d;
            store       <= store_d;
            add         <= add_d;
            mul         <= mul_d;
            done        <= done_d;
            instr_ready <= ready_d;
            halted      <= halted_d;
            addr_err    <= err_d;
            retired_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus random instructions checked cycle by cycle
// against a transaction-level model of each instruction's control waveform.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'd0;
    logic        invalidmemaddress = 1'b0;
    logic        instr_ready, loadreg, initialize, load, store, add, mul;
    logic        done, addr_err, halted;
    logic [2:0]  regnum;
    logic [8:0]  address;
    logic [15:0] retired_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned m_cnt = 0;
    bit          m_err = 1'b0;
    bit          m_halt = 1'b0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_valid       (instr_valid),
        .instr             (instr),
        .instr_ready       (instr_ready),
        .regnum            (regnum),
        .loadreg           (loadreg),
        .initialize        (initialize),
        .load              (load),
        .store             (store),
        .add               (add),
        .mul               (mul),
        .address           (address),
        .invalidmemaddress (invalidmemaddress),
        .done              (done),
        .addr_err          (addr_err),
        .halted            (halted),
        .retired_cnt       (retired_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {loadreg, initialize, load, store, add, mul, done};
    endfunction

    task automatic check_status(input string tag);
        check_eq({tag, "_ctrl"}, 32'(ctrl_vec()), 32'd0);
        check_eq({tag, "_cnt"}, 32'(retired_cnt), 32'(m_cnt[15:0]));
        check_eq({tag, "_err"}, 32'(addr_err), 32'(m_err));
        check_eq({tag, "_halted"}, 32'(halted), 32'(m_halt));
        check_eq({tag, "_ready"}, 32'(instr_ready), 32'(!m_halt));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_cnt = 0; m_err = 1'b0; m_halt = 1'b0;
        check_eq({tag, "_rst_ctrl"}, 32'(ctrl_vec()), 32'd0);
        check_eq({tag, "_rst_regnum"}, 32'(regnum), 32'd0);
        check_eq({tag, "_rst_addr"}, 32'(address), 32'd0);
        check_eq({tag, "_rst_flags"}, 32'({addr_err, halted}), 32'd0);
        check_eq({tag, "_rst_cnt"}, 32'(retired_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait for ready, hand over one instruction, then check every following cycle against
    // the waveform the instruction's rules imply.
    task automatic run_instr(input logic [2:0] op, input logic [1:0] rg, input logic [8:0] ad,
                             input logic inv);
        bit         acc = 1'b0;
        bit         rej, is_mem;
        int         ncyc;
        logic [6:0] ec;
        logic [2:0] er;
        logic [8:0] ea;
        bit         care_r, care_a;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            if (instr_ready) begin
                instr_valid       = 1'b1;
                instr             = {op, rg, 2'(($urandom)), ad};
                invalidmemaddress = inv;
                @(posedge clk);
                acc = 1'b1;
            end
        end
        if (!acc) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            return;
        end
        is_mem = (op == 3'd2) || (op == 3'd3);
        rej    = is_mem && (ad > 9'd496);
        ncyc   = (!rej && op == 3'd2) ? 3 : 2;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) begin
                instr_valid = 1'b0;
                instr       = 16'($urandom);
            end
            ec = 7'd0; er = 3'd0; ea = 9'd0; care_r = 1'b0; care_a = 1'b0;
            if (c == ncyc) begin
                ec = 7'b0000001;
            end else if (!rej && c == 2) begin
                ec = 7'b1000000; er = {1'b0, rg}; ea = ad; care_r = 1'b1; care_a = 1'b1;
            end else if (!rej) begin
                case (op)
                    3'd1: if (rg < 2) begin ec = 7'b1100000; er = {1'b0, rg}; care_r = 1'b1; end
                    3'd2: begin ec = 7'b0010000; er = {1'b0, rg}; ea = ad; care_r = 1; care_a = 1; end
                    3'd3: begin ec = 7'b0001000; er = {1'b0, rg}; ea = ad; care_r = 1; care_a = 1; end
                    3'd4: begin ec = 7'b1000100; er = 3'b100; care_r = 1'b1; end
                    3'd5: begin ec = 7'b1000010; er = 3'b100; care_r = 1'b1; end
                    default: ;
                endcase
            end
            check_eq($sformatf("op%0d_c%0d_ctrl", op, c), 32'(ctrl_vec()), 32'(ec));
            if (care_r) check_eq($sformatf("op%0d_c%0d_regnum", op, c), 32'(regnum), 32'(er));
            if (care_a) check_eq($sformatf("op%0d_c%0d_addr", op, c), 32'(address), 32'(ea));
            check_eq($sformatf("op%0d_c%0d_busy", op, c), 32'(instr_ready), 32'd0);
        end
        if (rej) m_err = 1'b1;
        else m_cnt++;
        if (!rej && is_mem && inv) m_err = 1'b1;
        if (op == 3'd6) m_halt = 1'b1;
        @(negedge clk);
        check_status($sformatf("op%0d_after", op));
    endtask

    task automatic halted_followup();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instr_valid = 1'b1;
            instr       = 16'($urandom);
            @(negedge clk);
            check_eq("halt_ignore_done", 32'(done), 32'd0);
            check_eq("halt_ready", 32'(instr_ready), 32'd0);
            check_eq("halt_flag", 32'(halted), 32'd1);
            check_eq("halt_cnt", 32'(retired_cnt), 32'(m_cnt[15:0]));
        end
        instr_valid = 1'b0;
        do_reset("halt");
        @(negedge clk);
        check_status("halt_reset");
    endtask

    initial begin
        logic [2:0] op;
        logic [8:0] ad;
        #1;
        check_eq("por_ctrl", 32'(ctrl_vec()), 32'd0);
        check_eq("por_cnt", 32'(retired_cnt), 32'd0);
        check_eq("por_flags", 32'({addr_err, halted}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_status("idle");

        run_instr(3'd1, 2'd0, 9'd0, 1'b0);
        run_instr(3'd1, 2'd1, 9'd0, 1'b0);
        check_eq("two_inits_cnt", 32'(retired_cnt), 32'd2);
        run_instr(3'd3, 2'd0, 9'd45, 1'b0);
        run_instr(3'd2, 2'd1, 9'd45, 1'b0);
        run_instr(3'd2, 2'd2, 9'd496, 1'b0);
        run_instr(3'd3, 2'd0, 9'd500, 1'b0);
        run_instr(3'd2, 2'd3, 9'd497, 1'b0);
        run_instr(3'd4, 2'd0, 9'd0, 1'b0);
        run_instr(3'd5, 2'd0, 9'd0, 1'b0);
        run_instr(3'd1, 2'd3, 9'd0, 1'b0);
        run_instr(3'd7, 2'd0, 9'd7, 1'b1);
        run_instr(3'd6, 2'd0, 9'd0, 1'b0);
        halted_followup();

        run_instr(3'd2, 2'd1, 9'd100, 1'b1);
        check_eq("invaddr_err", 32'(addr_err), 32'd1);
        do_reset("midwb_pre");

        // Reset asserted while the LOAD write-back cycle is in progress.
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = {3'd2, 2'd1, 2'd0, 9'd20};
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #2;
        check_eq("midwb_loadreg_before", 32'(loadreg), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midwb_loadreg_drop", 32'(loadreg), 32'd0);
        check_eq("midwb_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("midwb_no_done", 32'(done), 32'd0);
        end
        check_status("midwb_idle");

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom);
            ad = ($urandom_range(0, 3) == 0) ? 9'(494 + $urandom_range(0, 5)) : 9'($urandom);
            run_instr(op, 2'($urandom), ad, 1'($urandom));
            if (op == 3'd6) halted_followup();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
